instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch front-end of the RISC-V pipeline, acting as the initiator on the instruction-memory read port. It holds the PC, drives a word address to the combinational-read instruction memory, and captures the returned word together with its PC into a 2-entry fetch buffer. The buffer feeds the decode stage through a valid/ready handshake. Branch and jump redirects from execute flush the buffer and restart fetch at the target.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0013, value on `if_instr` while the buffer is empty (`addi x0,x0,0`).

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst_n  in  1  Reset, asynchronous, active-low.
- imem_addr  out  32  Byte address to instruction memory; equals the `pc` register, bits [1:0] always 0.
- imem_rdata  in  32  Instruction word; combinational from `imem_addr`, valid in the same cycle.
- redirect_valid  in  1  Execute requests a PC change this cycle.
- redirect_pc  in  32  Redirect target; bits [1:0] are ignored and cleared.
- if_valid  out  1  Buffer head holds an instruction.
- if_ready  in  1  Decode accepts the head this cycle.
- if_instr  out  32  Head instruction; NOP_INSTR when empty.
- if_pc  out  32  PC of the head instruction; 0 when empty.
- if_pc_plus4  out  32  `if_pc + 4` (mod 2^32); 0 when empty.
- misalign_err  out  1  Sticky flag, set when a redirect target has [1:0] != 0.

## Operation
- State: `pc` (32 bits); FIFO of 2 entries, each holding {pc, instr}; count 0..2; `misalign_err`.
- `push` = count<2, or (count==2 and `pop`). It captures {pc, imem_rdata} at the tail and advances pc <= pc+4. The PC wraps from 0xFFFF_FFFC to 0x0000_0000.
- `pop` = `if_valid & if_ready`. It removes the head.
- Simultaneous push and pop is legal at every count.
  - At count 2 with pop: one in, one out, count stays 2.
  - At count 0, the pushed entry is not visible until the next cycle. There is no bypass: the buffer is strictly registered.
- Redirect has priority over push and pop:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - count <= 0, all entries discarded.
  - No push occurs that cycle.
  - If [1:0] != 0, misalign_err <= 1. It is cleared only by reset.
- A handshake occurring in the same cycle as a redirect counts as a transfer from fetch's point of view. Decode is responsible for squashing it.
- Outputs are driven only from registers (head entry and count). There is no combinational path from `redirect_valid` or `if_ready` to `if_valid`, `if_instr` or `if_pc`.
- `if_ready` may toggle freely. When it is low, the head and its outputs are held stable.

## Timing
- Reset (async assert, synchronous-edge release):
  - pc = RESET_PC, count = 0.
  - if_valid = 0, if_instr = NOP_INSTR, if_pc = 0, if_pc_plus4 = 0.
  - misalign_err = 0, imem_addr = RESET_PC.
- First valid instruction: `if_valid` = 1 after the 1st rising edge following reset release.
- Steady state with `if_ready` held high: one instruction per cycle; PCs increment by 4 and are gap-free.
- Redirect sampled at edge N:
  - After edge N: `imem_addr` = target and if_valid = 0.
  - After edge N+1: `if_valid` = 1 with `if_pc` = target. Redirect-to-valid latency is 2 edges.
- `if_ready` low for K cycles: the buffer fills within 2 cycles, then pc stops advancing. Fetch resumes in the same cycle `if_ready` returns high.
- `rst_n` asserted mid-stream: all state returns to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset/stream:
  - Stimulus: memory words 0x00100093, 0x00200113, 0x0020c463, … at 0x0, 0x4, 0x8; `if_ready` = 1.
  - Required: consecutive accepts give if_pc = 0x0, 0x4, 0x8 with matching if_instr, one per cycle.
  - Required before first edge: if_valid = 0, if_instr = 0x00000013.
- Backpressure:
  - Stimulus: `if_ready` = 0 for 5 cycles after reset.
  - Required: imem_addr stalls at 0x8 with count 2, and the head stays if_pc = 0x0.
  - Required on release: 0x0, 0x4, 0x8, 0xC are delivered back-to-back, with no loss or duplicate.
- Redirect:
  - Stimulus: while streaming at pc 0xC, `redirect_valid` = 1 with redirect_pc = 0x10.
  - Required: next cycle if_valid = 0; the following cycle if_pc = 0x10, if_pc_plus4 = 0x14. No stale entry (0x8 or 0xC) appears after the redirect.
- Redirect with full buffer and handshake in the same cycle:
  - Stimulus: count 2, `if_ready` = 1, redirect to 0x8C.
  - Required: the buffer is emptied; the next valid if_pc = 0x8C.
- Misaligned redirect:
  - Stimulus: redirect_pc = 0x23.
  - Required: imem_addr = 0x20; misalign_err = 1, staying 1 through later redirects until rst_n = 0.
- Wrap and async reset:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Required: 0xFFFF_FFFC is followed by if_pc = 0x0000_0000, with if_pc_plus4 = 0x0 for the first.
  - Stimulus: drop rst_n mid-cycle.
  - Required: outputs return to reset values before the next edge.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch front-end, instruction memory, execute and decode.
// The master side is the fetch unit. The slave side is its environment.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        misalign_err;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pc_plus4,
    output misalign_err
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pc_plus4,
    input  misalign_err
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch front-end.
// It keeps the PC and reads one word per cycle from the combinational instruction memory.
// Fetched {pc, instr} pairs are queued in a strictly registered 2-entry buffer.
// The buffer head is presented to decode through a valid/ready handshake.
// A redirect from execute flushes the buffer and restarts fetch at the target.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] pc;
  entry_t      slot0;        // head of the buffer
  entry_t      slot1;        // second entry, valid only when count == 2
  logic [1:0]  count;
  logic        misalign_err;

  logic        pop;
  logic        push;
  entry_t      fetched;

  // Handshake decode. A push is always possible unless the buffer is full and nothing leaves.
  always_comb begin
    pop     = (count != 2'd0) & bus.if_ready;
    push    = (count != 2'd2) | pop;
    fetched = '{pc: pc, instr: bus.imem_rdata};
  end

  // PC, buffer and sticky error update. A redirect overrides any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      slot0        <= '0;
      slot1        <= '0;
      count        <= 2'd0;
      misalign_err <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc    <= {bus.redirect_pc[31:2], 2'b00};
      count <= 2'd0;
      if (bus.redirect_pc[1:0] != 2'b00)
        misalign_err <= 1'b1;
    end else begin
      if (push)
        pc <= pc + 32'd4;
      case (count)
        2'd0: begin
          slot0 <= fetched;
          count <= 2'd1;
        end
        2'd1: begin
          if (pop) begin
            slot0 <= fetched;
          end else begin
            slot1 <= fetched;
            count <= 2'd2;
          end
        end
        default: begin
          // Buffer is full. Move up one entry only when the head is taken.
          if (pop) begin
            slot0 <= slot1;
            slot1 <= fetched;
          end
        end
      endcase
    end
  end

  // The outputs depend only on registered head and count state.
  assign bus.imem_addr    = pc;
  assign bus.if_valid     = (count != 2'd0);
  assign bus.if_instr     = (count != 2'd0) ? slot0.instr : NOP_INSTR;
  assign bus.if_pc        = (count != 2'd0) ? slot0.pc : 32'd0;
  assign bus.if_pc_plus4  = (count != 2'd0) ? slot0.pc + 32'd4 : 32'd0;
  assign bus.misalign_err = misalign_err;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch.
// It runs directed test-plan scenarios with literal expectations, then randomized traffic.
// A queue-based reference model is checked against the DUT on every falling edge.
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  instr_fetch_if bus ();

  instr_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: the test-plan words at 0x0..0x8, a hash of the address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0: mem_word = 32'h0010_0093;
      32'h4: mem_word = 32'h0020_0113;
      32'h8: mem_word = 32'h0020_c463;
      default: mem_word = {a[15:0] ^ 16'h5a5a, a[31:16]} + 32'h1357_9bdf;
    endcase
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  // Reference model: fetch PC, a queue holding at most two entries, and the sticky error flag.
  logic [31:0] m_pc = 32'h0;
  ent_t        m_q[$];
  logic        m_err = 1'b0;

  task automatic model_step();
    bit pop_now;
    bit push_now;
    if (bus.redirect_valid) begin
      m_q.delete();
      m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
      if (bus.redirect_pc[1:0] != 2'b00) m_err = 1'b1;
    end else begin
      pop_now  = (m_q.size() > 0) && bus.if_ready;
      push_now = (m_q.size() < 2) || pop_now;
      if (pop_now) void'(m_q.pop_front());
      if (push_now) begin
        m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Advance the model on each edge. Reset it asynchronously, as the DUT is reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pc  = 32'h0;
      m_err = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (m_q.size() > 0) begin
      chk("if_valid", {31'd0, bus.if_valid}, 32'd1);
      chk("if_pc", bus.if_pc, m_q[0].pc);
      chk("if_instr", bus.if_instr, m_q[0].instr);
      chk("if_pc_plus4", bus.if_pc_plus4, m_q[0].pc + 32'd4);
    end else begin
      chk("if_valid", {31'd0, bus.if_valid}, 32'd0);
      chk("if_pc", bus.if_pc, 32'd0);
      chk("if_instr", bus.if_instr, 32'h0000_0013);
      chk("if_pc_plus4", bus.if_pc_plus4, 32'd0);
    end
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_err});
  end

  // Apply inputs for the coming edge, then return 1 ns after that edge.
  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, bus.if_valid}, 32'd0);
    chk({tag, "_instr"}, bus.if_instr, 32'h0000_0013);
    chk({tag, "_pc"}, bus.if_pc, 32'd0);
    chk({tag, "_pc4"}, bus.if_pc_plus4, 32'd0);
    chk({tag, "_addr"}, bus.imem_addr, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.misalign_err}, 32'd0);
  endtask

  // Assert reset mid-cycle, check the outputs before any edge, and release it away from the edge.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals(tag);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] tgt;

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.if_ready       = 1'b1;
    #1 chk_reset_vals("rst0");
    #11 rst_n = 1'b1;

    // Streaming with ready held high.
    cyc(1'b0, 32'd0, 1'b1);
    chk("s0_pc", bus.if_pc, 32'h0);
    chk("s0_instr", bus.if_instr, 32'h0010_0093);
    cyc(1'b0, 32'd0, 1'b1);
    chk("s1_pc", bus.if_pc, 32'h4);
    chk("s1_instr", bus.if_instr, 32'h0020_0113);
    cyc(1'b0, 32'd0, 1'b1);
    chk("s2_pc", bus.if_pc, 32'h8);
    chk("s2_instr", bus.if_instr, 32'h0020_c463);
    chk("s2_addr", bus.imem_addr, 32'hC);

    // Redirect while streaming.
    cyc(1'b1, 32'h10, 1'b1);
    chk("r_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("r_addr", bus.imem_addr, 32'h10);
    cyc(1'b0, 32'd0, 1'b1);
    chk("r_pc", bus.if_pc, 32'h10);
    chk("r_pc4", bus.if_pc_plus4, 32'h14);
    cyc(1'b0, 32'd0, 1'b1);
    chk("r_next", bus.if_pc, 32'h14);

    // Backpressure after a fresh reset.
    async_reset("rst1");
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b0);
    chk("bp_addr", bus.imem_addr, 32'h8);
    chk("bp_head", bus.if_pc, 32'h0);
    chk("bp_valid", {31'd0, bus.if_valid}, 32'd1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("bp_d1", bus.if_pc, 32'h4);
    cyc(1'b0, 32'd0, 1'b1);
    chk("bp_d2", bus.if_pc, 32'h8);
    chk("bp_d2_instr", bus.if_instr, 32'h0020_c463);
    cyc(1'b0, 32'd0, 1'b1);
    chk("bp_d3", bus.if_pc, 32'hC);
    chk("bp_addr2", bus.imem_addr, 32'h14);

    // Redirect with a full buffer and a handshake in the same cycle.
    cyc(1'b1, 32'h8C, 1'b1);
    chk("rf_valid", {31'd0, bus.if_valid}, 32'd0);
    cyc(1'b0, 32'd0, 1'b1);
    chk("rf_pc", bus.if_pc, 32'h8C);
    chk("rf_err", {31'd0, bus.misalign_err}, 32'd0);

    // Misaligned redirect sets the sticky flag.
    cyc(1'b1, 32'h23, 1'b1);
    chk("mis_addr", bus.imem_addr, 32'h20);
    chk("mis_err", {31'd0, bus.misalign_err}, 32'd1);
    cyc(1'b1, 32'h40, 1'b1);
    chk("mis_sticky", {31'd0, bus.misalign_err}, 32'd1);

    // PC wrap at the top of the address space.
    cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
    cyc(1'b0, 32'd0, 1'b1);
    chk("w_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("w_pc4", bus.if_pc_plus4, 32'h0);
    chk("w_addr", bus.imem_addr, 32'h0);
    cyc(1'b0, 32'd0, 1'b1);
    chk("w_next", bus.if_pc, 32'h0);
    chk("w_err", {31'd0, bus.misalign_err}, 32'd1);

    // Asynchronous reset in the middle of the stream.
    async_reset("rst2");

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      if (n == 1000) async_reset("rst3");
      case ($urandom_range(0, 3))
        0: tgt = 32'($urandom_range(0, 255));
        1: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        2: tgt = $urandom;
        default: tgt = 32'($urandom_range(0, 1023)) << 2;
      endcase
      cyc(($urandom_range(0, 99) < 6) ? 1'b1 : 1'b0, tgt,
          ($urandom_range(0, 99) < 65) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
